// File: rtl/fill_pkg.sv
// Shared types and constants for the cache-line word fill sequencer.
package fill_pkg;

    localparam int WORDS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/word_fill_sequencer_onehot_decode.sv
// Index to one-hot decoder used for the data-array word write enables.
module onehot_decode #(
    parameter  int WORDS = 8,
    localparam int IDX_W = $clog2(WORDS)
) (
    input  logic [IDX_W-1:0] idx,
    output logic [WORDS-1:0] onehot
);

    assign onehot = WORDS'(1) << idx;

endmodule

// File: rtl/word_fill_sequencer.sv
// Cache-line fill sequencer: steps word enables through one line per fill.
// Define FILL_WRAP_EN for critical-word-first fills starting at start_word.
module word_fill_sequencer
    import fill_pkg::*;
#(
    parameter  int WORDS = WORDS_DEFAULT,
    localparam int IDX_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] start_word,
    input  logic             abort,
    input  logic             mem_valid,
    output logic             mem_ready,
    output logic [WORDS-1:0] word_enable,
    output logic [IDX_W-1:0] word_idx,
    output logic [WORDS-1:0] valid_mask,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] count;
    logic [IDX_W-1:0] first_idx;
    logic [WORDS-1:0] dec;
    logic             xfer;

`ifdef FILL_WRAP_EN
    assign first_idx = start_word;
`else
    logic unused_start_word;
    assign unused_start_word = ^start_word;
    assign first_idx = '0;
`endif

    assign mem_ready   = (state == FILL);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign xfer        = mem_valid && mem_ready && !abort;
    assign word_enable = xfer ? dec : '0;

    onehot_decode #(
        .WORDS (WORDS)
    ) u_decode (
        .idx    (word_idx),
        .onehot (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = FILL;
            FILL: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (xfer && count == LAST) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Mask is only cleared by a new start or an abort, so it survives in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx   <= '0;
            count      <= '0;
            valid_mask <= '0;
        end else if (state == IDLE && start) begin
            word_idx   <= first_idx;
            count      <= '0;
            valid_mask <= '0;
        end else if (state == FILL && abort) begin
            valid_mask <= '0;
        end else if (xfer) begin
            valid_mask[word_idx] <= 1'b1;
            word_idx             <= word_idx + 1'b1;
            count                <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_word_fill_sequencer.sv
// Scoreboard bench for word_fill_sequencer (WORDS=8), default or FILL_WRAP_EN build.
module tb_word_fill_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] start_word;
    logic       abort;
    logic       mem_valid;
    logic       mem_ready;
    logic [7:0] word_enable;
    logic [2:0] word_idx;
    logic [7:0] valid_mask;
    logic       busy;
    logic       done;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    word_fill_sequencer #(.WORDS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_word  (start_word),
        .abort       (abort),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .word_enable (word_enable),
        .word_idx    (word_idx),
        .valid_mask  (valid_mask),
        .busy        (busy),
        .done        (done)
    );

    function automatic logic [2:0] first_word(input logic [2:0] sw);
`ifdef FILL_WRAP_EN
        return sw;
`else
        return 3'd0;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start_word = 3'd0;
        abort = 1'b0; mem_valid = 1'b1;
        #12;
        n_cmp++;
        if ({busy, done, mem_ready} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 000", {busy, done, mem_ready});
        end
        n_cmp++;
        if (word_enable !== 8'h00 || valid_mask !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_vec en=%h mask=%h want 00/00", word_enable, valid_mask);
        end
        n_cmp++;
        if (word_idx !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_idx got %0d want 0", word_idx);
        end
        mem_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_fill(input logic [2:0] sw);
        start = 1'b1; start_word = sw;
        #1;
        n_cmp++;
        if (mem_ready !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL start_idle ready=%b busy=%b want 0/0", mem_ready, busy);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || mem_ready !== 1'b1 || valid_mask !== 8'h00) begin
            n_bad++;
            $display("FAIL start_fill busy=%b ready=%b mask=%h want 1/1/00",
                     busy, mem_ready, valid_mask);
        end
        n_cmp++;
        if (word_idx !== first_word(sw)) begin
            n_bad++;
            $display("FAIL start_idx got %0d want %0d", word_idx, first_word(sw));
        end
        @(negedge clk);
    endtask

    task automatic run_fill(input logic [2:0] sw, input bit gap, input bit poke);
        logic [2:0] idx;
        logic [7:0] mask;
        logic [7:0] e;
        int         n;
        int         cyc;
        idx = first_word(sw); mask = 8'h00; n = 0; cyc = 0;
        while (n < 8 && cyc < 40) begin
            mem_valid  = gap ? (cyc % 2 == 0) : 1'b1;
            start      = poke && (cyc == 2);
            start_word = 3'd3;
            q.push_back(mem_valid ? (8'(1) << idx) : 8'h00);
            #1;
            e = q.pop_front();
            n_cmp++;
            if (word_enable !== e) begin
                n_bad++;
                $display("FAIL fill_enable cyc=%0d got %h want %h", cyc, word_enable, e);
            end
            n_cmp++;
            if (word_idx !== idx || valid_mask !== mask) begin
                n_bad++;
                $display("FAIL fill_state cyc=%0d idx=%0d mask=%h want %0d/%h",
                         cyc, word_idx, valid_mask, idx, mask);
            end
            n_cmp++;
            if (done !== 1'b0) begin
                n_bad++;
                $display("FAIL fill_early_done cyc=%0d got %b want 0", cyc, done);
            end
            @(posedge clk);
            if (mem_valid) begin
                mask[idx] = 1'b1;
                idx++;
                n++;
            end
            cyc++;
            @(negedge clk);
        end
        mem_valid = 1'b0; start = 1'b0;
        n_cmp++;
        if (n != 8) begin
            n_bad++;
            $display("FAIL fill_timeout transfers=%0d want 8", n);
        end
        #1;
        n_cmp++;
        if ({done, busy, mem_ready} !== 3'b110 || valid_mask !== 8'hff) begin
            n_bad++;
            $display("FAIL fill_done d/b/r=%b mask=%h want 110/ff",
                     {done, busy, mem_ready}, valid_mask);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({done, busy} !== 2'b00 || valid_mask !== 8'hff) begin
            n_bad++;
            $display("FAIL fill_after d/b=%b mask=%h want 00/ff", {done, busy}, valid_mask);
        end
        @(negedge clk);
    endtask

    task automatic test_linear();
        start_fill(3'd0);
        run_fill(3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        start_fill(3'd5);
        run_fill(3'd5, 1'b0, 1'b0);
    endtask

    task automatic test_gapped();
        start_fill(3'd2);
        run_fill(3'd2, 1'b1, 1'b0);
    endtask

    task automatic test_start_in_fill();
        start_fill(3'd6);
        run_fill(3'd6, 1'b0, 1'b1);
    endtask

    task automatic test_idle_ignore();
        mem_valid = 1'b1; abort = 1'b1;
        #1;
        n_cmp++;
        if (word_enable !== 8'h00 || mem_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_ignore en=%h ready=%b want 00/0", word_enable, mem_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (valid_mask !== 8'hff || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_hold mask=%h busy=%b want ff/0", valid_mask, busy);
        end
        mem_valid = 1'b0; abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        start_fill(3'd0);
        mem_valid = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        #1;
        n_cmp++;
        if (word_enable !== 8'h00 || valid_mask !== 8'h07) begin
            n_bad++;
            $display("FAIL abort_cycle en=%h mask=%h want 00/07", word_enable, valid_mask);
        end
        @(negedge clk);
        abort = 1'b0; mem_valid = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, mem_ready} !== 3'b000 || valid_mask !== 8'h00) begin
            n_bad++;
            $display("FAIL abort_idle b/d/r=%b mask=%h want 000/00",
                     {busy, done, mem_ready}, valid_mask);
        end
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_done got %b want 0", done);
            end
        end
    endtask

    task automatic test_async_reset();
        start_fill(3'd0);
        mem_valid = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, mem_ready} !== 3'b000 || word_enable !== 8'h00) begin
            n_bad++;
            $display("FAIL areset_out b/d/r=%b en=%h want 000/00",
                     {busy, done, mem_ready}, word_enable);
        end
        n_cmp++;
        if (valid_mask !== 8'h00 || word_idx !== 3'd0) begin
            n_bad++;
            $display("FAIL areset_state mask=%h idx=%0d want 00/0", valid_mask, word_idx);
        end
        mem_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL areset_after d/b=%b want 00", {done, busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_idle_ignore();
        test_wrap();
        test_gapped();
        test_start_in_fill();
        test_abort();
        test_linear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/word_fill_sequencer.md
WORD_FILL_SEQUENCER -- requirements
Module: word_fill_sequencer

Interface
REQ-001 SHALL have parameter WORDS, default 8, giving words per line (power of two, 2..64).
REQ-002 SHALL have derived localparam IDX_W, equal to log2(WORDS), giving the word-index width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a line fill.
REQ-006 SHALL have port start_word, input, IDX_W bits: critical word index, sampled with start.
REQ-007 SHALL have port abort, input, 1 bit: cancel the fill in progress.
REQ-008 SHALL have port mem_valid, input, 1 bit: memory presents a data word.
REQ-009 SHALL have port mem_ready, output, 1 bit: the sequencer accepts a word.
REQ-010 SHALL have port word_enable, output, WORDS bits: one-hot write enable for the data-array word.
REQ-011 SHALL have port word_idx, output, IDX_W bits: index of the word currently expected.
REQ-012 SHALL have port valid_mask, output, WORDS bits: words written so far in this fill.
REQ-013 SHALL have port busy, output, 1 bit: high in FILL or DONE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse on fill completion.

Function
REQ-015 SHALL implement states IDLE, FILL and DONE.
REQ-016 IDLE + start SHALL go to FILL next cycle, load word_idx from the first-word rule, clear valid_mask and clear the transfer count.
REQ-017 start in FILL or DONE SHALL be ignored.
REQ-018 abort in IDLE or DONE SHALL be ignored.
REQ-019 mem_ready SHALL equal (state==FILL), combinationally.
REQ-020 A transfer SHALL be mem_valid && mem_ready && !abort.
REQ-021 word_enable SHALL be onehot(word_idx) in a transfer cycle and all-zero otherwise (combinational, zero latency).
REQ-022 Each transfer SHALL set valid_mask[word_idx] at the next edge.
REQ-023 Each transfer SHALL advance word_idx by 1 modulo WORDS (wraps WORDS-1 to 0).
REQ-024 Each transfer SHALL increment the transfer count.
REQ-025 A transfer with count==WORDS-1 SHALL move FILL to DONE, leaving valid_mask all-ones.
REQ-026 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-027 abort in FILL SHALL suppress that cycle's word_enable, go to IDLE next cycle, clear valid_mask and never assert done.
REQ-028 mem_valid outside FILL SHALL have no effect.
REQ-029 valid_mask SHALL hold its value in IDLE after a completed fill until the next start.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, word_idx 0, count 0 and valid_mask 0.
REQ-031 With rst_n low, done, busy, mem_ready and word_enable SHALL all be 0.
REQ-032 Reset mid-fill SHALL discard the fill without a done pulse.

Configuration
REQ-033 SHALL use macro FILL_WRAP_EN to select the first-word rule.
REQ-034 With FILL_WRAP_EN defined: first word_idx = start_word (critical-word-first), wrapping through all WORDS words.
REQ-035 Without FILL_WRAP_EN: start_word SHALL be ignored and the fill SHALL always run 0..WORDS-1 in order.

Structure
REQ-036 Package fill_pkg SHALL hold the state encoding (IDLE=0, FILL=1, DONE=2) and the default WORDS constant.
REQ-037 Sub-module onehot_decode (parameter WORDS; index in, one-hot out) SHALL generate word_enable, instantiated once.

Verification (WORDS=8)
REQ-038 SHALL test reset-then-linear fill: start, start_word=0, mem_valid held -> word_enable 01,02,...,80 on consecutive cycles; done one cycle after the 80 cycle; valid_mask=FF.
REQ-039 SHALL test wrap fill (FILL_WRAP_EN): start_word=5 -> enables 20,40,80,01,02,04,08,10; done once.
REQ-040 SHALL test gapped data: mem_valid toggled 1,0,1,0 -> word_enable zero in gap cycles and word_idx held; fill completes after 8 transfers.
REQ-041 SHALL test abort: abort with mem_valid on the 4th word -> word_enable 00 that cycle, IDLE next cycle, valid_mask 00, no done.
REQ-042 SHALL test start in FILL: start with start_word=3 in FILL -> sequence undisturbed.
REQ-043 SHALL test async reset: rst_n low mid-fill -> outputs zero immediately without waiting for clk.
